// File: rtl/iic_slave_regif_pkg.sv
// rtl/iic_slave_regif_pkg.sv - shared I2C target FSM states and bus constants
// Purpose: state encoding and ACK/NACK levels shared by the I2C target and master.
// Contents: iic_state_e (4-bit FSM states), IIC_ACK/IIC_NACK, drives_ack() helper.
package iic_slave_regif_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } iic_state_e;

    localparam logic IIC_ACK  = 1'b0;
    localparam logic IIC_NACK = 1'b1;

    // States in which the target pulls SDA low for the whole ACK bit.
    function automatic logic drives_ack(input iic_state_e s);
        return (s == ST_ADDR_ACK) || (s == ST_PTR_ACK) || (s == ST_WDATA_ACK);
    endfunction

endpackage

// File: rtl/iic_line_filter.sv
// rtl/iic_line_filter.sv - 2-FF synchroniser, glitch filter and edge pulses for one bus line
// Purpose: accept a new line level only after it has been stable FILTER_LEN clk.
// Ports: clk, rstn (sync active-low), line_i (async pin), level_o (filtered level),
//        rise_o / fall_o (1-clk pulses, coincident with the level_o change).
module iic_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1_q, sync2_q, level_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // The synced level has differed from the accepted level for FILTER_LEN clk.
    assign accept = (sync2_q != level_q) && (cnt_q == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // Idle bus lines are high; start there so reset does not fake an edge.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            rise_q  <= accept && sync2_q;
            fall_q  <= accept && !sync2_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/iic_slave_regif.sv
// rtl/iic_slave_regif.sv - I2C target endpoint with a synchronous register-file port
// Purpose: decode START/STOP, device ID, register pointer and data; ACK and return read data.
// Ports: clk, rstn (sync active-low), scl_in/sda_in (async bus), sda_out/sda_out_en (open-drain
//        drive), busy, reg_addr (pointer), wr_en/wr_data (write strobe), rd_en/rd_data (read).
module iic_slave_regif
    import iic_slave_regif_pkg::*;
#(
    parameter logic [6:0] DEVICE_ID  = 7'h2B,
    parameter int         ADDR_BYTE  = 1,
    parameter int         FILTER_LEN = 3,
    parameter int         SDA_HOLD   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_out,
    output logic                   sda_out_en,
    output logic                   busy,
    output logic [ADDR_BYTE*8-1:0] reg_addr,
    output logic                   wr_en,
    output logic [7:0]             wr_data,
    output logic                   rd_en,
    input  logic [7:0]             rd_data
);

    localparam int AW = ADDR_BYTE * 8;
    localparam int HW = $clog2(SDA_HOLD + 1);

    logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(clk), .rstn(rstn), .line_i(scl_in),
        .level_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(clk), .rstn(rstn), .line_i(sda_in),
        .level_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    iic_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          got_bit_q, got_bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic [1:0]    ptr_cnt_q, ptr_cnt_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic          busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rd_en_q, rd_en_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_lat_q, rd_lat_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          sda_en_q, sda_en_d;

    logic start_det, stop_det, byte_last, want_drive;

    assign start_det = sda_fall && scl_f;
    assign stop_det  = sda_rise && scl_f;
    assign byte_last = (bit_cnt_q == 3'd7);
    // Read data is open-drain: only 0 bits are driven.
    assign want_drive = drives_ack(state_q) || ((state_q == ST_RDATA) && !shift_q[7]);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        got_bit_d  = got_bit_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ptr_cnt_d  = ptr_cnt_q;
        reg_addr_d = reg_addr_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = rd_pend_q;
        rd_pend_d  = 1'b0;
        rd_lat_d   = rd_en_q;
        hold_cnt_d = hold_cnt_q;
        sda_en_d   = sda_en_q;

        if (wr_en_q) reg_addr_d = reg_addr_q + AW'(1);
        if (rd_lat_q) shift_d = rd_data;

        // SDA only changes SDA_HOLD clk after SCL fell, never while SCL is high.
        if (scl_fall) begin
            hold_cnt_d = HW'(SDA_HOLD);
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
            if (hold_cnt_q == HW'(1)) sda_en_d = want_drive;
        end

        // got_bit makes the SCL fall that follows START (no bit sampled yet) a no-op.
        if (scl_rise) begin
            got_bit_d = 1'b1;
            if (state_q inside {ST_ADDR, ST_PTR, ST_WDATA}) shift_d = {shift_q[6:0], sda_f};
            if (state_q == ST_RDATA_ACK) begin
                if (sda_f == IIC_NACK) begin
                    state_d = ST_IGNORE;
                end else begin
                    reg_addr_d = reg_addr_q + AW'(1);
                    rd_pend_d  = 1'b1;
                end
            end
        end

        if (scl_fall && got_bit_q) begin
            got_bit_d = 1'b0;
            case (state_q)
                ST_ADDR: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_last) begin
                        if (shift_q[7:1] == DEVICE_ID) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            rd_en_d = shift_q[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    bit_cnt_d = 3'd0;
                    ptr_cnt_d = 2'd0;
                    state_d   = rw_q ? ST_RDATA : ST_PTR;
                end
                ST_PTR: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_last) begin
                        reg_addr_d = (reg_addr_q << 8) | AW'(shift_q);
                        ptr_cnt_d  = ptr_cnt_q + 2'd1;
                        state_d    = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK: begin
                    bit_cnt_d = 3'd0;
                    state_d   = (ptr_cnt_q == 2'(ADDR_BYTE)) ? ST_WDATA : ST_PTR;
                end
                ST_WDATA: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_last) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = shift_q;
                        state_d   = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_WDATA;
                end
                ST_RDATA: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = {shift_q[6:0], 1'b1};
                    if (byte_last) state_d = ST_RDATA_ACK;
                end
                ST_RDATA_ACK: begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_RDATA;
                end
                default: ;
            endcase
        end

        if (start_det || stop_det) begin
            state_d    = start_det ? ST_ADDR : ST_IDLE;
            bit_cnt_d  = 3'd0;
            got_bit_d  = 1'b0;
            busy_d     = 1'b0;
            sda_en_d   = 1'b0;
            hold_cnt_d = '0;
            rd_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            got_bit_q  <= 1'b0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ptr_cnt_q  <= 2'd0;
            reg_addr_q <= '0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            rd_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_lat_q   <= 1'b0;
            hold_cnt_q <= '0;
            sda_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            got_bit_q  <= got_bit_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ptr_cnt_q  <= ptr_cnt_d;
            reg_addr_q <= reg_addr_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_pend_q  <= rd_pend_d;
            rd_lat_q   <= rd_lat_d;
            hold_cnt_q <= hold_cnt_d;
            sda_en_q   <= sda_en_d;
        end
    end

    assign sda_out    = !sda_en_q;
    assign sda_out_en = sda_en_q;
    assign busy       = busy_q;
    assign reg_addr   = reg_addr_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign rd_en      = rd_en_q;

endmodule
